program_sequencer: RTL
======================

# program_sequencer

Autonomous instruction feeder for the simple bus processor (mv/mvi/add/sub, 9-bit instructions). It fetches instructions from a synchronous program ROM and presents them on the processor's `din`. It pulses `run` at the processor's t0 and supplies the immediate word for mvi during t1. It then waits for `done`, advances the program counter, and halts after the last program address. It supports free-running and single-step modes, a retired-instruction counter, and a watchdog that flags a processor that never asserts `done`.

## Interface
Parameters:
- `DATA_WIDTH`, 9, instruction/bus width; opcode is `din[DATA_WIDTH-1:DATA_WIDTH-3]`
- `ADDR_WIDTH`, 5, program ROM address width
- `COUNT_WIDTH`, 8, retired-instruction counter width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins execution at address 0; ignored while `busy`
- `step_mode`  in  1  1 = pause after each instruction
- `step`  in  1  one-cycle pulse; releases one instruction while paused
- `last_addr`  in  ADDR_WIDTH  address of the final program word
- `mem_addr`  out  ADDR_WIDTH  ROM address
- `mem_data`  in  DATA_WIDTH  ROM word, valid one cycle after `mem_addr`
- `din`  out  DATA_WIDTH  processor data-in bus
- `run`  out  1  processor run request
- `done`  in  1  processor instruction-complete, combinational from processor
- `busy`  out  1  high from `start` acceptance until halt/error
- `halted`  out  1  sticky; program finished normally
- `error`  out  1  sticky; watchdog expired
- `instr_count`  out  COUNT_WIDTH  instructions retired since `start`; wraps

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, PAUSE, HALT, ERR.
- IDLE:
  - `start` with `step_mode`=0 -> FETCH; with `step_mode`=1 -> PAUSE.
  - On acceptance: pc=0, `instr_count`=0, `halted`=0, `error`=0.
- FETCH: `mem_addr`=pc -> ISSUE.
- ISSUE:
  - `din`=`mem_data`, `run`=1, `mem_addr`=pc+1 (immediate prefetch).
  - Latch opcode -> WAIT; clear watchdog count.
- WAIT:
  - `din`=`mem_data` (immediate word; harmless for non-mvi), `run`=0.
  - On `done`: `instr_count`+1; next pc = pc+2 if the latched opcode is mvi (001), else pc+1.
  - If the next pc exceeds `last_addr` (computed in ADDR_WIDTH+1 bits, so ROM wrap also counts as exceeding) -> HALT.
  - Otherwise -> PAUSE if `step_mode`, else FETCH.
- WAIT watchdog: the 4th consecutive WAIT cycle without `done` -> ERR.
- PAUSE: `step` -> FETCH; `start` is ignored.
- HALT: `halted`=1; `start` restarts as from IDLE.
- ERR: `error`=1; `start` restarts as from IDLE.
- `busy`=1 in FETCH/ISSUE/WAIT/PAUSE.
- `done` outside WAIT is ignored.
- `done` and the watchdog limit in the same cycle: `done` wins.
- `step` and `step_mode` falling in PAUSE: `step` alone releases; after that instruction, `step_mode`=0 continues free-running.
- mvi whose immediate lies beyond `last_addr`: the immediate is still fetched (pc+1), then halt.

## Timing
- Reset values: state IDLE, pc=0, `mem_addr`=0, `din`=0, `run`=0, `busy`=0, `halted`=0, `error`=0, `instr_count`=0.
- `rst` mid-instruction aborts immediately; the processor shares `rst` and resets alongside.
- `din`=0 in IDLE, FETCH, PAUSE, HALT and ERR.
- ISSUE coincides with processor t0; WAIT cycle 1 is t1.
- Per-instruction latency, FETCH to next FETCH: mv/mvi 3 cycles, add/sub 5 cycles.
- `start` pulse to first `run`: 2 cycles.
- `halted` rises the cycle after the final `done`.

## Structure
- Shared package `processor_pkg`:
  - opcode constants MV=000, MVI=001, ADD=010, SUB=011
  - opcode field position derived from DATA_WIDTH
  - sequencer state enum
- No sub-module is needed: single FSM plus a pc register, 2-bit watchdog counter and instruction counter.

## Test plan
- ROM {0:mvi r0 (001_000_000), 1:0x005, 2:mv r1,r0 (000_001_000)}, `last_addr`=2, `start` -> `run` in ISSUE at addresses 0 and 2; `din`=0x005 during the mvi t1; `instr_count`=2; `halted`=1; total 6 cycles after FETCH entry.
- add r0,r1 (010_000_001) at address 0, `last_addr`=0 -> `done` on the 3rd WAIT cycle; `halted` 1 cycle later; `instr_count`=1.
- Processor model never asserts `done` -> `error`=1 after 4 WAIT cycles; `busy`=0; `run` stays 0.
- `step_mode`=1, 3-instruction program -> each `step` retires exactly one instruction; no `run` between steps; `start` in PAUSE ignored.
- `rst` asserted in WAIT of an add -> next cycle all outputs at reset values; a later `start` re-executes from address 0.
- `last_addr`=31 with mvi at address 30 -> next pc 32 overflows -> HALT with no wrap to address 0.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared definitions for the simple bus processor and its program sequencer.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package processor_pkg;

    // Opcode field occupies the top OPC_W bits of an instruction word
    localparam int OPC_W = 3;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_MV  = 3'b000;
    localparam opcode_t OP_MVI = 3'b001;
    localparam opcode_t OP_ADD = 3'b010;
    localparam opcode_t OP_SUB = 3'b011;

    // Value of the WAIT-cycle count on the last tolerated cycle without done
    localparam logic [1:0] WD_LIMIT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_PAUSE,
        S_HALT,
        S_ERR
    } seq_state_t;

    // Lowest bit of the opcode field for a given instruction width
    function automatic int opc_lsb(input int data_width);
        return data_width - OPC_W;
    endfunction

endpackage

// File: rtl/program_sequencer.sv
// Fetches instructions from a synchronous ROM and feeds them to the bus processor.
// Latency: start to first run 2 cycles; FETCH to FETCH 3 cycles (mv/mvi), 5 (add/sub).
// Backpressure: holds in WAIT until done (watchdog to ERR after 4 cycles); PAUSE holds until step.
module program_sequencer
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH  = 9,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   step_mode,
    input  logic                   step,
    input  logic [ADDR_WIDTH-1:0]  last_addr,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    output logic [DATA_WIDTH-1:0]  din,
    output logic                   run,
    input  logic                   done,
    output logic                   busy,
    output logic                   halted,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam int OPC_LSB = opc_lsb(DATA_WIDTH);

    seq_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH:0]    pc_inc;
    logic [1:0]             wd_cnt;
    opcode_t                opcode;
    logic                   accept;

    // Next pc one bit wider than the ROM address so running off the end is visible
    always_comb begin
        pc_inc = {1'b0, pc} + ((opcode == OP_MVI) ? (ADDR_WIDTH+1)'(2) : (ADDR_WIDTH+1)'(1));
    end

    // Next-state and processor-facing outputs
    always_comb begin
        state_nxt = state;
        mem_addr  = pc;
        din       = '0;
        run       = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = step_mode ? S_PAUSE : S_FETCH;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                din       = mem_data;
                run       = 1'b1;
                // Prefetch the word after the instruction: the mvi immediate lands in t1
                mem_addr  = pc + ADDR_WIDTH'(1);
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy     = 1'b1;
                din      = mem_data;
                // Hold the prefetch address so the immediate stays on din
                mem_addr = pc + ADDR_WIDTH'(1);
                if (done) begin
                    if (pc_inc > {1'b0, last_addr}) begin
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = step_mode ? S_PAUSE : S_FETCH;
                    end
                end else if (wd_cnt == WD_LIMIT) begin
                    state_nxt = S_ERR;
                end
            end
            S_PAUSE: begin
                busy = 1'b1;
                if (step) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Program counter, opcode latch, watchdog, retire counter and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            opcode      <= OP_MV;
            wd_cnt      <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
            error       <= 1'b0;
        end else begin
            if (accept) begin
                pc          <= '0;
                instr_count <= '0;
                halted      <= 1'b0;
                error       <= 1'b0;
            end
            if (state == S_ISSUE) begin
                opcode <= mem_data[OPC_LSB +: OPC_W];
                wd_cnt <= '0;
            end
            if (state == S_WAIT) begin
                if (done) begin
                    instr_count <= instr_count + COUNT_WIDTH'(1);
                    pc          <= pc_inc[ADDR_WIDTH-1:0];
                end else begin
                    wd_cnt <= wd_cnt + 2'd1;
                end
            end
            if (state != S_HALT && state_nxt == S_HALT) begin
                halted <= 1'b1;
            end
            if (state != S_ERR && state_nxt == S_ERR) begin
                error <= 1'b1;
            end
        end
    end

endmodule
